// File: rtl/hog_block_normalizer.sv
// HOG block normalizer: L1 block sum, per-bin bit-serial restoring division.
// Optional macro NORM_EPS_EN adds EPSILON to the block sum.
module hog_block_normalizer #(
   parameter int BIN_WIDTH       = 14,
   parameter int BINS            = 9,
   parameter int CELLS_PER_BLOCK = 4,
   parameter int OUT_BITS        = 4,
   parameter int GAIN_SHIFT      = 0,
   parameter int EPSILON         = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic in_ready,
   input  logic k_border,
   input  logic [BIN_WIDTH*(BINS+1)*CELLS_PER_BLOCK-1:0] block_histograms,
   output logic out_valid,
   input  logic out_ready,
   output logic out_border,
   output logic [CELLS_PER_BLOCK*BINS*OUT_BITS-1:0] normalized_block
);

   localparam int NB = CELLS_PER_BLOCK * BINS;
   localparam int FW = (BINS + 1) * BIN_WIDTH;
`ifdef NORM_EPS_EN
   localparam int SW      = BIN_WIDTH + $clog2(CELLS_PER_BLOCK) + 1;
   localparam int EPS_ADD = EPSILON;
`else
   localparam int SW      = BIN_WIDTH + $clog2(CELLS_PER_BLOCK);
   localparam int EPS_ADD = EPSILON * 0;
`endif
   localparam int DW = BIN_WIDTH + GAIN_SHIFT;
   localparam int RW = ((DW > SW) ? DW : SW) + 1;
   localparam int CW = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;

   typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

   state_t              r_state;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_out_border;
   logic                r_border;
   logic [CW-1:0]       r_cnt;
   logic [SW-1:0]       r_sum;
   logic [NB-1:0]       r_sat;
   logic [RW-1:0]       r_rem [NB];
   logic [OUT_BITS-1:0] r_q   [NB];
   logic [NB*OUT_BITS-1:0] r_out;

   logic [SW-1:0]       w_sum;
   logic [RW-1:0]       w_d   [NB];
   logic [NB-1:0]       w_sat;
   logic [RW-1:0]       w_r2  [NB];
   logic [RW-1:0]       w_rn  [NB];
   logic [NB-1:0]       w_bit;
   logic [OUT_BITS-1:0] w_qn  [NB];
   logic [OUT_BITS-1:0] w_res [NB];
   logic                w_szero;

   always_comb begin
      w_sum = SW'(EPS_ADD);
      for (int c = 0; c < CELLS_PER_BLOCK; c++) begin
         w_sum = w_sum + SW'(block_histograms[c*FW + BINS*BIN_WIDTH +: BIN_WIDTH]);
      end
      for (int c = 0; c < CELLS_PER_BLOCK; c++) begin
         for (int b = 0; b < BINS; b++) begin
            w_d[c*BINS+b] =
               RW'(block_histograms[c*FW + b*BIN_WIDTH +: BIN_WIDTH]) << GAIN_SHIFT;
            w_sat[c*BINS+b] = (w_d[c*BINS+b] >= RW'(w_sum));
         end
      end
   end

`ifdef NORM_EPS_EN
   assign w_szero = 1'b0;
`else
   assign w_szero = (r_sum == '0);
`endif

   // One restoring step per bin; the final quotient is formed combinationally
   // so the HOLD load happens on the same edge as the last step.
   always_comb begin
      for (int n = 0; n < NB; n++) begin
         w_r2[n]  = r_rem[n] << 1;
         w_bit[n] = (w_r2[n] >= RW'(r_sum));
         w_rn[n]  = w_bit[n] ? (w_r2[n] - RW'(r_sum)) : w_r2[n];
         w_qn[n]  = OUT_BITS'({r_q[n], w_bit[n]});
         if (r_border || w_szero)
            w_res[n] = '0;
         else if (r_sat[n])
            w_res[n] = '1;
         else
            w_res[n] = w_qn[n];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_in_ready   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_border <= 1'b0;
         r_border     <= 1'b0;
         r_cnt        <= '0;
         r_sum        <= '0;
         r_sat        <= '0;
         r_out        <= '0;
         for (int n = 0; n < NB; n++) begin
            r_rem[n] <= '0;
            r_q[n]   <= '0;
         end
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_in_ready <= 1'b0;
                  r_state    <= DIV;
                  r_cnt      <= '0;
                  r_sum      <= w_sum;
                  r_sat      <= w_sat;
                  r_border   <= k_border;
                  for (int n = 0; n < NB; n++) begin
                     r_rem[n] <= w_d[n];
                     r_q[n]   <= '0;
                  end
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            DIV: begin
               r_cnt <= r_cnt + 1'b1;
               for (int n = 0; n < NB; n++) begin
                  r_rem[n] <= w_rn[n];
                  r_q[n]   <= w_qn[n];
               end
               if (r_cnt == CW'(OUT_BITS - 1)) begin
                  r_state      <= HOLD;
                  r_out_valid  <= 1'b1;
                  r_out_border <= r_border;
                  for (int n = 0; n < NB; n++) begin
                     r_out[n*OUT_BITS +: OUT_BITS] <= w_res[n];
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready         = r_in_ready;
   assign out_valid        = r_out_valid;
   assign out_border       = r_out_border;
   assign normalized_block = r_out;

endmodule
